instr_decode_ctrl: RTL

//  Registered, handshaked successor to the combinational instruction decoder. Accepts one

---
 rtl/instr_decode_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_decode_ctrl.sv
// Registered, handshaked instruction decoder: IDLE -> DECODE -> EXEC, issuing one-cycle control strobes.
// Optional macro DECODE_COND_JMP_EN turns JEZ/JNZ into conditional jumps on acc_zero (otherwise NOP).

`ifndef NOP
`define NOP 5'h00
`endif
`ifndef JMP
`define JMP 5'h01
`endif
`ifndef JEZ
`define JEZ 5'h02
`endif
`ifndef JNZ
`define JNZ 5'h03
`endif
`ifndef ST
`define ST  5'h04
`endif
`ifndef RST
`define RST 5'h05
`endif

module instr_decode_ctrl #(
  parameter int OPC_WIDTH   = 5,
  parameter int UNDEFINED   = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int REG_BIT_CNT = 3,
  parameter int CNTR_WIDTH  = 8,
  localparam int COMBINED_DATA = OPC_WIDTH + UNDEFINED + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [COMBINED_DATA-1:0] instr_in,
  input  logic                     acc_zero,
  output logic [OPC_WIDTH-1:0]     opcode,
  output logic [REG_BIT_CNT-1:0]   reg_sel,
  output logic [CNTR_WIDTH-1:0]    jmp_addr,
  output logic                     jmp,
  output logic                     load,
  output logic                     store,
  output logic                     rst_req_f,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

  state_t                state;
  state_t                next_state;
  logic [OPC_WIDTH-1:0]  ir_opcode;
  logic [DATA_WIDTH-1:0] ir_operand;
  logic                  accept;
  logic                  dec_jmp;
  logic                  dec_load;
  logic                  dec_store;
  logic                  dec_rst;
  logic                  unused_bits;

  assign accept   = instr_valid && instr_ready;
  assign opcode   = ir_opcode;
  assign reg_sel  = ir_operand[DATA_WIDTH-1 -: REG_BIT_CNT];
  assign jmp_addr = ir_operand[CNTR_WIDTH-1:0];

  // Pad bits and operand bits between the register and target fields carry no meaning.
`ifdef DECODE_COND_JMP_EN
  assign unused_bits = ^{instr_in[DATA_WIDTH +: UNDEFINED], ir_operand};
`else
  assign unused_bits = ^{instr_in[DATA_WIDTH +: UNDEFINED], ir_operand, acc_zero};
`endif

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = DECODE;
      DECODE:  next_state = EXEC;
      EXEC:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobe decode is only meaningful while in DECODE; acc_zero is sampled there.
  always_comb begin
    instr_ready = (state == IDLE);
    busy        = (state != IDLE);
    dec_jmp     = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_rst     = 1'b0;
    case (ir_opcode)
      `JMP: dec_jmp = 1'b1;
`ifdef DECODE_COND_JMP_EN
      `JEZ: dec_jmp = acc_zero;
      `JNZ: dec_jmp = ~acc_zero;
`else
      `JEZ, `JNZ: ;
`endif
      `RST: dec_rst   = 1'b1;
      `NOP: ;
      `ST:  dec_store = 1'b1;
      default: dec_load = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      ir_opcode  <= '0;
      ir_operand <= '0;
    end else if (accept) begin
      ir_opcode  <= instr_in[COMBINED_DATA-1 -: OPC_WIDTH];
      ir_operand <= instr_in[DATA_WIDTH-1:0];
    end
  end

  // Strobes are registered on the DECODE->EXEC edge so they live exactly for EXEC.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      jmp       <= 1'b0;
      load      <= 1'b0;
      store     <= 1'b0;
      rst_req_f <= 1'b1;
    end else if (state == DECODE) begin
      jmp       <= dec_jmp;
      load      <= dec_load;
      store     <= dec_store;
      rst_req_f <= ~dec_rst;
    end else begin
      jmp       <= 1'b0;
      load      <= 1'b0;
      store     <= 1'b0;
      rst_req_f <= 1'b1;
    end
  end

endmodule
